// File: rtl/ej32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_pkg
//  Description : Shared types and constants for the eJ32 divide engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package ej32_pkg;

  localparam int DIV_DSZ = 32;
  localparam logic [DIV_DSZ-1:0] DIV_INT_MIN = DIV_DSZ'(1) << (DIV_DSZ - 1);

  typedef enum logic [2:0] {
    dIDLE = 3'd0,
    dLOAD = 3'd1,
    dITER = 3'd2,
    dFIX  = 3'd3,
    dDONE = 3'd4
  } div_st_t;

endpackage : ej32_pkg
`default_nettype wire

// File: rtl/div_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : div_rr_arb
//  Description : Two-port round-robin arbiter. On a tie the port that was not
//                granted last wins; a lone requester always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_rr_arb (
  input  logic [1:0] req_v_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  // One-hot grant from the request vector and the last-granted port index.
  always_comb begin
    gnt_o = 2'b00;
    case (req_v_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule : div_rr_arb
`default_nettype wire

// File: rtl/ej32_div_arb.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_div_arb
//  Description : Shared 32-bit signed/unsigned radix-2 restoring divider with
//                a two-port round-robin front end and Java result semantics
//                (truncation toward zero, x/0 flagged, INT_MIN/-1 wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module ej32_div_arb
  import ej32_pkg::*;
#(
  parameter int DSZ = DIV_DSZ,
  parameter int CW  = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     req_v,
  output logic [1:0]     req_r,
  input  logic [1:0]     req_sgn,
  input  logic [DSZ-1:0] x0,
  input  logic [DSZ-1:0] y0,
  input  logic [DSZ-1:0] x1,
  input  logic [DSZ-1:0] y1,
  output logic [1:0]     rsp_v,
  input  logic [1:0]     rsp_r,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r,
  output logic           dz,
  output logic           busy
);

  localparam logic [DSZ-1:0] c_INT_MIN = {1'b1, {(DSZ-1){1'b0}}};

  div_st_t        state_q, state_d;
  logic           gsel_q, gsel_d;
  logic           last_q, last_d;
  logic           sgn_q, sgn_d;
  logic           negq_q, negq_d;
  logic           negr_q, negr_d;
  logic [DSZ-1:0] x_q, x_d;
  logic [DSZ-1:0] y_q, y_d;
  logic [DSZ-1:0] dvd_q, dvd_d;   // dividend shifts out, quotient shifts in
  logic [DSZ-1:0] dvs_q, dvs_d;
  logic [DSZ-1:0] rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DSZ-1:0] q_q, q_d;
  logic [DSZ-1:0] r_q, r_d;
  logic           dz_q, dz_d;

  logic [1:0]     w_gnt;
  logic [DSZ:0]   w_rem_sh;
  logic [DSZ-1:0] w_diff;
  logic           w_ge;
  logic [DSZ-1:0] w_xmag;
  logic [DSZ-1:0] w_ymag;

  div_rr_arb u_arb (
    .req_v_i (req_v),
    .last_i  (last_q),
    .gnt_o   (w_gnt)
  );

  // The shifted partial remainder needs DSZ+1 bits: the divisor magnitude can
  // reach 2^DSZ-1, so the remainder before shifting may already have its MSB set.
  assign w_rem_sh = {rem_q, dvd_q[DSZ-1]};
  assign w_ge     = w_rem_sh >= {1'b0, dvs_q};
  assign w_diff   = w_rem_sh[DSZ-1:0] - dvs_q;
  assign w_xmag   = (sgn_q && x_q[DSZ-1]) ? -x_q : x_q;
  assign w_ymag   = (sgn_q && y_q[DSZ-1]) ? -y_q : y_q;

  assign rsp_v = (state_q == dDONE) ? (gsel_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy  = (state_q != dIDLE);
  assign q     = q_q;
  assign r     = r_q;
  assign dz    = dz_q;

  // Next-state, datapath update and request-ready strobe.
  always_comb begin
    state_d = state_q;
    gsel_d  = gsel_q;
    last_d  = last_q;
    sgn_d   = sgn_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    x_d     = x_q;
    y_d     = y_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    req_r   = 2'b00;
    case (state_q)
      dIDLE: begin
        if (|req_v) begin
          req_r   = w_gnt;
          gsel_d  = w_gnt[1];
          sgn_d   = req_sgn[w_gnt[1]];
          x_d     = w_gnt[1] ? x1 : x0;
          y_d     = w_gnt[1] ? y1 : y0;
          state_d = dLOAD;
        end
      end
      dLOAD: begin
        negq_d = sgn_q & (x_q[DSZ-1] ^ y_q[DSZ-1]);
        negr_d = sgn_q & x_q[DSZ-1];
        dvd_d  = w_xmag;
        dvs_d  = w_ymag;
        rem_d  = '0;
        cnt_d  = CW'(DSZ - 1);
        if (y_q == '0) begin
          q_d     = '0;
          r_d     = x_q;
          dz_d    = 1'b1;
          state_d = dDONE;
        end else if (sgn_q && (x_q == c_INT_MIN) && (y_q == '1)) begin
          q_d     = c_INT_MIN;
          r_d     = '0;
          dz_d    = 1'b0;
          state_d = dDONE;
        end else begin
          state_d = dITER;
        end
      end
      dITER: begin
        rem_d = w_ge ? w_diff : w_rem_sh[DSZ-1:0];
        dvd_d = {dvd_q[DSZ-2:0], w_ge};
        if (cnt_q == '0) begin
          state_d = dFIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      dFIX: begin
        q_d     = negq_q ? -dvd_q : dvd_q;
        r_d     = negr_q ? -rem_q : rem_q;
        dz_d    = 1'b0;
        state_d = dDONE;
      end
      dDONE: begin
        if (rsp_r[gsel_q]) begin
          last_d  = gsel_q;
          state_d = dIDLE;
        end
      end
      default: state_d = dIDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= dIDLE;
      gsel_q  <= 1'b0;
      last_q  <= 1'b1;
      sgn_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gsel_q  <= gsel_d;
      last_q  <= last_d;
      sgn_q   <= sgn_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
    end
  end

endmodule : ej32_div_arb
`default_nettype wire

// File: tb/tb_ej32_div_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ej32_div_arb
//  Description : Self-checking bench for ej32_div_arb: directed cases plus
//                randomized two-port traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ej32_div_arb;
  import ej32_pkg::*;

  localparam int DSZ = 32;
  localparam int CW  = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [1:0]     req_v = '0;
  logic [1:0]     req_r;
  logic [1:0]     req_sgn = '0;
  logic [DSZ-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic [1:0]     rsp_v;
  logic [1:0]     rsp_r = '0;
  logic [DSZ-1:0] q, r;
  logic           dz, busy;

  int errors = 0;
  int checks = 0;

  ej32_div_arb #(.DSZ(DSZ), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req_v(req_v), .req_r(req_r), .req_sgn(req_sgn),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .rsp_v(rsp_v), .rsp_r(rsp_r),
    .q(q), .r(r), .dz(dz), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Java-semantics reference division using 64-bit arithmetic.
  function automatic void ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eq, output logic [31:0] er, output bit edz);
    longint a, b;
    if (y == 32'd0) begin
      eq = '0; er = x; edz = 1'b1;
    end else begin
      edz = 1'b0;
      if (sgn) begin
        a = longint'($signed(x));
        b = longint'($signed(y));
      end else begin
        a = longint'({32'd0, x});
        b = longint'({32'd0, y});
      end
      eq = 32'(a / b);
      er = 32'(a % b);
    end
  endfunction

  function automatic int arb(input logic [1:0] rq, input int last);
    if (rq == 2'b11) return (last == 1) ? 0 : 1;
    if (rq == 2'b01) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] rv();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return DIV_INT_MIN;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Behavioural model: idle/busy/done with a latency countdown.
  bit          m_ok = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  int          m_g = 0, m_last = 1, m_cnt = 0;
  logic [31:0] m_q = '0, m_r = '0;
  bit          m_dz = 1'b0;

  initial begin
    logic [31:0] mx, my;
    bit          ms;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_ok = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_last = 1;
      end else if (m_ok) begin
        if (!m_busy) begin
          if (req_v != 2'b00) begin
            m_g = arb(req_v, m_last);
            mx  = (m_g == 1) ? x1 : x0;
            my  = (m_g == 1) ? y1 : y0;
            ms  = req_sgn[m_g];
            ref_div(ms, mx, my, m_q, m_r, m_dz);
            m_cnt  = (m_dz || (ms && mx == DIV_INT_MIN && my == 32'hFFFF_FFFF)) ? 1 : DSZ + 2;
            m_busy = 1'b1;
            m_done = 1'b0;
          end
        end else if (!m_done) begin
          m_cnt--;
          if (m_cnt == 0) m_done = 1'b1;
        end else if (rsp_r[m_g]) begin
          m_busy = 1'b0; m_done = 1'b0; m_last = m_g;
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    logic [1:0] e_rr, e_rv;
    forever begin
      @(negedge clk);
      if (rst && m_ok) begin
        e_rr = (!m_busy && req_v != 2'b00) ? 2'(1 << arb(req_v, m_last)) : 2'b00;
        e_rv = m_done ? 2'(1 << m_g) : 2'b00;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("req_r", 32'(req_r), 32'(e_rr));
        chk("req_r_onehot", 32'($onehot0(req_r)), 32'd1);
        chk("rsp_v", 32'(rsp_v), 32'(e_rv));
        if (m_done) begin
          chk("q", q, m_q);
          chk("r", r, m_r);
          chk("dz", 32'(dz), 32'(m_dz));
        end
      end
    end
  end

  task automatic set_port(input int p, input bit sgn, input logic [31:0] x, input logic [31:0] y);
    req_v[p]   = 1'b1;
    req_sgn[p] = sgn;
    if (p == 0) begin x0 = x; y0 = y; end
    else        begin x1 = x; y1 = y; end
  endtask

  // Directed operation; caller is at posedge+#1.
  task automatic dir_op(input string nm, input int p, input bit sgn, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eq, input logic [31:0] er,
                        input bit edz, input int elat, input int hold, input bit other);
    int k;
    int w;
    logic [31:0] mq, mr;
    bit mdz;
    ref_div(sgn, x, y, mq, mr, mdz);
    chk({nm, "_model_q"}, mq, eq);
    chk({nm, "_model_r"}, mr, er);
    set_port(p, sgn, x, y);
    w = 0;
    @(negedge clk);
    while (!req_r[p] && w < 100) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    if (!req_r[p]) begin
      chk({nm, "_grant_timeout"}, 32'd1, 32'd0);
      req_v[p] = 1'b0;
      @(posedge clk); #1;
      return;
    end
    @(posedge clk); #1;
    req_v[p] = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rsp_v[p] && k < 100) begin
      @(posedge clk); k++; @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(k), 32'(elat));
    chk({nm, "_q"}, q, eq);
    chk({nm, "_r"}, r, er);
    chk({nm, "_dz"}, 32'(dz), 32'(edz));
    if (other) begin
      @(posedge clk); #1;
      set_port(1 - p, 1'b0, 32'd50, 32'd5);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_rsp_v"}, 32'(rsp_v), 32'(1 << p));
      chk({nm, "_hold_q"}, q, eq);
      chk({nm, "_hold_r"}, r, er);
      chk({nm, "_hold_req_r"}, 32'(req_r), 32'd0);
    end
    @(posedge clk); #1;
    rsp_r[p] = 1'b1;
    @(posedge clk); #1;
    rsp_r[p] = 1'b0;
  endtask

  initial begin
    logic [1:0] seen;
    int w;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rsp_v", 32'(rsp_v), 32'd0);
    chk("reset_q", q, 32'd0);
    chk("reset_r", r, 32'd0);
    @(posedge clk); #1;

    dir_op("neg7_div_2", 0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 0, 1'b0);
    dir_op("7_div_neg2", 0, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, 0, 1'b0);
    dir_op("udiv_p1", 1, 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34, 0, 1'b0);
    dir_op("ovf_p1", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1, 0, 1'b0);
    dir_op("dz_p0", 0, 1'b1, 32'd123, 32'd0, 32'd0, 32'd123, 1'b1, 1, 0, 1'b0);
    dir_op("dz_p1", 1, 1'b0, 32'd123, 32'd0, 32'd0, 32'd123, 1'b1, 1, 0, 1'b0);

    // Backpressure with the other port waiting; it must be granted right after.
    dir_op("bp", 0, 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1, 1'b0, 34, 10, 1'b1);
    @(negedge clk);
    chk("bp_next_grant", 32'(req_r), 32'd2);
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    rsp_r = 2'b11;
    repeat (40) @(posedge clk);
    #1 rsp_r = 2'b00;

    // Continuous requests from reset: grants alternate starting with port 0.
    rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    set_port(0, 1'b0, 32'd123, 32'd0);
    set_port(1, 1'b0, 32'd9, 32'd0);
    rsp_r = 2'b11;
    for (int i = 0; i < 4; i++) begin
      w = 0;
      @(negedge clk);
      while (req_r == 2'b00 && w < 20) begin
        @(posedge clk); #1; @(negedge clk); w++;
      end
      chk("alt_grant", 32'(req_r), (i % 2 == 0) ? 32'd1 : 32'd2);
      @(posedge clk); #1;
    end
    req_v = 2'b00;
    repeat (5) @(posedge clk);
    #1 rsp_r = 2'b00;

    // Reset in the middle of an iteration aborts it.
    set_port(0, 1'b1, 32'h1234_5678, 32'h123);
    w = 0;
    @(negedge clk);
    while (!req_r[0] && w < 20) begin
      @(posedge clk); #1; @(negedge clk); w++;
    end
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rsp_v", 32'(rsp_v), 32'd0);
    chk("abort_req_r", 32'(req_r), 32'd0);
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_dz", 32'(dz), 32'd0);
    @(posedge clk); #1;
    dir_op("100_div_7", 0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0, 1'b0);

    // Randomized two-port traffic with random response backpressure.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      seen = req_r;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!req_v[p] || seen[p] || $urandom_range(0, 15) == 0) begin
          req_v[p]   = ($urandom_range(0, 2) != 0);
          req_sgn[p] = 1'($urandom_range(0, 1));
          if (p == 0) begin x0 = rv(); y0 = rv(); end
          else        begin x1 = rv(); y1 = rv(); end
        end
      end
      rsp_r[0] = ($urandom_range(0, 3) != 0);
      rsp_r[1] = ($urandom_range(0, 3) != 0);
    end

    req_v = 2'b00;
    rsp_r = 2'b11;
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_ej32_div_arb
`default_nettype wire
